// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_pipe execute-stage ALU.
// Opcode encoding, flag bit positions, multiplier FSM states and the
// per-opcode flag-write mask. The multiply opcode is only executed when
// the ALU_MUL_EN macro is defined; otherwise it decodes as a NOP.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_NOT  = 4'd1,
        OP_INC  = 4'd2,
        OP_DEC  = 4'd3,
        OP_MOV  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SETC = 4'd11,
        OP_CLRC = 4'd12,
        OP_MUL  = 4'd13
    } alu_op_e;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_MUL  = 1'b1
    } mul_state_e;

    // Which of Z/N/C an opcode writes. A zero-distance shift keeps C.
    function automatic logic [2:0] flag_write_mask(input alu_op_e op, input logic shamt_zero);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_NOT, OP_AND, OP_OR: begin
                m = 3'b011;
            end
            OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_MUL: begin
                m = 3'b111;
            end
            OP_SHL, OP_SHR: begin
                m = shamt_zero ? 3'b011 : 3'b111;
            end
            OP_SETC, OP_CLRC: begin
                m = 3'b100;
            end
            default: begin
                m = 3'b000;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue/result handshake bundle between decode and the ALU.
// master = the issuing/consuming side, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic             flag_save;
    logic             flag_restore;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    modport master (
        output in_valid, op, op_a, op_b, shamt, flag_save, flag_restore, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, op_a, op_b, shamt, flag_save, flag_restore, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier (used with ALU_MUL_EN).
// The first partial product is folded in on the start edge, the remaining
// WIDTH-1 are added one per cycle, so the full product sits in acc_r while
// done is high, WIDTH cycles after start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    mul_state_e         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic               done_r;

    // Multiplier FSM: load on start, one shift-add per cycle, exit on last count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= MS_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                MS_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r  <= MS_MUL;
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
                        mcand_r  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                        mplier_r <= {1'b0, b[WIDTH-1:1]};
                    end else begin
                        state_r <= MS_IDLE;
                    end
                end
                MS_MUL: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= MS_IDLE;
                        cnt_r   <= {CW{1'b0}};
                        done_r  <= 1'b0;
                    end else begin
                        acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
                        mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        done_r   <= (cnt_r == CNT_PEN);
                    end
                end
                default: begin
                    state_r <= MS_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = (state_r == MS_MUL);
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake,
// Z/N/C flag register and a one-deep shadow for interrupt save/restore.
// Optional feature macro: ALU_MUL_EN adds an iterative multiply on opcode 13
// (alu_mul_seq); without it opcode 13 is a NOP and the ALU is never busy.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    alu_op_e          op_eff_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   ext_a_s;
    logic [WIDTH:0]   ext_b_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic [2:0]       mask_s;
    logic [2:0]       op_flags_s;
    logic [2:0]       flags_upd_s;
    logic             busy_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             issue_s;

    logic [WIDTH-1:0] result_r;
    logic             out_valid_r;
    logic [2:0]       flags_r;
    logic [2:0]       shadow_r;

    assign shamt_s    = bus.shamt;
    assign ext_a_s    = {1'b0, bus.op_a};
    assign ext_b_s    = {1'b0, bus.op_b};
    assign in_ready_s = !busy_s && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign issue_s    = accept_s && (op_eff_s != OP_MUL);

`ifdef ALU_MUL_EN
    logic               mul_start_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    assign mul_start_s = accept_s && (op_eff_s == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .busy    (busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );
`else
    assign busy_s = 1'b0;
`endif

    // Map raw opcode to an executable op; unused encodings become NOP
    always_comb begin
        op_eff_s = OP_NOP;
        if (bus.op <= 4'd12) begin
            op_eff_s = alu_op_e'(bus.op);
        end
`ifdef ALU_MUL_EN
        else if (bus.op == 4'd13) begin
            op_eff_s = OP_MUL;
        end
`endif
        else begin
            op_eff_s = OP_NOP;
        end
    end

    // Single-cycle datapath: result and carry/borrow at WIDTH+1 bits
    always_comb begin
        wide_s  = {(WIDTH+1){1'b0}};
        res_s   = {WIDTH{1'b0}};
        carry_s = flags_r[FLG_C];
        case (op_eff_s)
            OP_NOT: begin
                res_s = ~bus.op_b;
            end
            OP_INC: begin
                wide_s  = ext_b_s + ONE_X;
                res_s   = wide_s[WIDTH-1:0];
                carry_s = wide_s[WIDTH];
            end
            OP_DEC: begin
                wide_s  = ext_b_s - ONE_X;
                res_s   = wide_s[WIDTH-1:0];
                carry_s = wide_s[WIDTH];
            end
            OP_MOV: begin
                res_s = bus.op_a;
            end
            OP_ADD: begin
                wide_s  = ext_a_s + ext_b_s;
                res_s   = wide_s[WIDTH-1:0];
                carry_s = wide_s[WIDTH];
            end
            OP_SUB: begin
                wide_s  = ext_b_s - ext_a_s;
                res_s   = wide_s[WIDTH-1:0];
                carry_s = wide_s[WIDTH];
            end
            OP_AND: begin
                res_s = bus.op_a & bus.op_b;
            end
            OP_OR: begin
                res_s = bus.op_a | bus.op_b;
            end
            OP_SHL: begin
                // bit WIDTH of the shifted value is b[WIDTH-shamt]
                wide_s  = ext_b_s << shamt_s;
                res_s   = wide_s[WIDTH-1:0];
                carry_s = wide_s[WIDTH];
            end
            OP_SHR: begin
                // bit 0 of the shifted value is b[shamt-1]
                wide_s  = {bus.op_b, 1'b0} >> shamt_s;
                res_s   = wide_s[WIDTH:1];
                carry_s = wide_s[0];
            end
            OP_SETC: begin
                carry_s = 1'b1;
            end
            OP_CLRC: begin
                carry_s = 1'b0;
            end
            default: begin
                res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Merge the op's (or multiplier's) flag writes onto the current flags
    always_comb begin
        mask_s            = flag_write_mask(op_eff_s, shamt_s == {SHW{1'b0}});
        op_flags_s        = 3'b000;
        op_flags_s[FLG_Z] = (res_s == {WIDTH{1'b0}});
        op_flags_s[FLG_N] = res_s[WIDTH-1];
        op_flags_s[FLG_C] = carry_s;
        flags_upd_s       = flags_r;
`ifdef ALU_MUL_EN
        if (mul_done_s) begin
            flags_upd_s[FLG_Z] = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flags_upd_s[FLG_N] = mul_prod_s[WIDTH-1];
            flags_upd_s[FLG_C] = |mul_prod_s[2*WIDTH-1:WIDTH];
        end else if (issue_s) begin
            for (int i = 0; i < 3; i++) begin
                flags_upd_s[i] = mask_s[i] ? op_flags_s[i] : flags_r[i];
            end
        end else begin
            flags_upd_s = flags_r;
        end
`else
        if (issue_s) begin
            for (int i = 0; i < 3; i++) begin
                flags_upd_s[i] = mask_s[i] ? op_flags_s[i] : flags_r[i];
            end
        end else begin
            flags_upd_s = flags_r;
        end
`endif
    end

    // Result/valid register, flag register and shadow; restore beats save
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r    <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            flags_r     <= 3'b000;
            shadow_r    <= 3'b000;
        end else begin
`ifdef ALU_MUL_EN
            if (mul_done_s) begin
                result_r    <= mul_prod_s[WIDTH-1:0];
                out_valid_r <= 1'b1;
            end else if (issue_s) begin
                result_r    <= res_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
`else
            if (issue_s) begin
                result_r    <= res_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
`endif
            flags_r <= bus.flag_restore ? shadow_r : flags_upd_s;
            if (bus.flag_save && !bus.flag_restore) begin
                shadow_r <= flags_upd_s;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven directed bench for alu_pipe (WIDTH=16).
// Flags are written {C,N,Z}. Multiply sequences run when ALU_MUL_EN is defined.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;
    localparam int NV = 30;

    logic clk;
    logic rst;

    alu_pipe_if #(.WIDTH(W), .SHW(4)) bus ();

    alu_pipe #(.WIDTH(W), .SHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] exp_res;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vt [NV];
    int n_vec;
    int n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sh, input logic [15:0] r, input logic [2:0] f);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.exp_res = r; v.exp_flags = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh,
                         input logic sv, input logic rs);
        bus.in_valid     = v;
        bus.op           = op;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.shamt        = sh;
        bus.flag_save    = sv;
        bus.flag_restore = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic sv, input logic rs);
        drive(1'b1, op, a, b, 4'd0, sv, rs);
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input logic [2:0] f);
        drive(1'b1, OP_MUL, a, b, 4'd0, 1'b0, 1'b0);
        #1;
        check("mul in_ready before", {31'd0, bus.in_ready}, 32'd1);
        tick();
        // keep another op pending; it must not be taken while busy
        drive(1'b1, OP_NOT, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) begin
            check($sformatf("mul busy out_valid c%0d", k), {31'd0, bus.out_valid}, 32'd0);
            check($sformatf("mul busy in_ready c%0d", k), {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        check("mul out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("mul result", {16'd0, bus.result}, {16'd0, r});
        check("mul flags", {29'd0, bus.flags}, {29'd0, f});
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        //            op       a         b         sh    result    {C,N,Z}
        vt[0]  = mk(OP_ADD,  16'h0001, 16'hFFFF, 4'd0,  16'h0000, 3'b101);
        vt[1]  = mk(OP_SUB,  16'h0005, 16'h0003, 4'd0,  16'hFFFE, 3'b110);
        vt[2]  = mk(OP_MOV,  16'h0000, 16'h1234, 4'd0,  16'h0000, 3'b110);
        vt[3]  = mk(OP_SHL,  16'h0000, 16'h8001, 4'd1,  16'h0002, 3'b100);
        vt[4]  = mk(OP_CLRC, 16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b000);
        vt[5]  = mk(OP_SHR,  16'h0000, 16'h0001, 4'd0,  16'h0001, 3'b000);
        vt[6]  = mk(OP_SETC, 16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b100);
        vt[7]  = mk(OP_SHL,  16'h0000, 16'h1234, 4'd0,  16'h1234, 3'b100);
        vt[8]  = mk(OP_SHR,  16'h0000, 16'h0003, 4'd1,  16'h0001, 3'b100);
        vt[9]  = mk(OP_SHR,  16'h0000, 16'h8000, 4'd15, 16'h0001, 3'b000);
        vt[10] = mk(OP_SHL,  16'h0000, 16'h0001, 4'd15, 16'h8000, 3'b010);
        vt[11] = mk(OP_SETC, 16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b110);
        vt[12] = mk(OP_NOT,  16'h0000, 16'hFFFF, 4'd0,  16'h0000, 3'b101);
        vt[13] = mk(OP_INC,  16'h0000, 16'h7FFF, 4'd0,  16'h8000, 3'b010);
        vt[14] = mk(OP_INC,  16'h0000, 16'hFFFF, 4'd0,  16'h0000, 3'b101);
        vt[15] = mk(OP_DEC,  16'h0000, 16'h0000, 4'd0,  16'hFFFF, 3'b110);
        vt[16] = mk(OP_DEC,  16'h0000, 16'h0001, 4'd0,  16'h0000, 3'b001);
        vt[17] = mk(OP_AND,  16'hF0F0, 16'hFF00, 4'd0,  16'hF000, 3'b010);
        vt[18] = mk(OP_OR,   16'h00F0, 16'h0F00, 4'd0,  16'h0FF0, 3'b000);
        vt[19] = mk(OP_ADD,  16'h7FFF, 16'h0001, 4'd0,  16'h8000, 3'b010);
        vt[20] = mk(OP_SUB,  16'h0003, 16'h0005, 4'd0,  16'h0002, 3'b000);
        vt[21] = mk(OP_SUB,  16'h0005, 16'h0005, 4'd0,  16'h0000, 3'b001);
        vt[22] = mk(OP_NOP,  16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 3'b001);
        vt[23] = mk(4'd14,   16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 3'b001);
        vt[24] = mk(4'd15,   16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 3'b001);
        vt[25] = mk(OP_MOV,  16'hABCD, 16'h0000, 4'd0,  16'hABCD, 3'b001);
        vt[26] = mk(OP_SUB,  16'h0001, 16'h0000, 4'd0,  16'hFFFF, 3'b110);
        vt[27] = mk(OP_SHR,  16'h0000, 16'hF0F0, 4'd5,  16'h0787, 3'b100);
        vt[28] = mk(OP_SHL,  16'h0000, 16'h0F0F, 4'd4,  16'hF0F0, 3'b010);
        vt[29] = mk(OP_ADD,  16'h8000, 16'h8000, 4'd0,  16'h0000, 3'b101);

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset result", {16'd0, bus.result}, 32'd0);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset flags", {29'd0, bus.flags}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        // table: one op per cycle with continuous out_ready
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].sh, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d result", i), {16'd0, bus.result}, {16'd0, vt[i].exp_res});
            check($sformatf("vec%0d flags", i), {29'd0, bus.flags}, {29'd0, vt[i].exp_flags});
            check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
        end
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check("drain out_valid", {31'd0, bus.out_valid}, 32'd0);

        // flag save / restore
        op1(OP_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("sr add0 flags", {29'd0, bus.flags}, 32'b001);
        op1(OP_SETC, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check("sr setc+save flags", {29'd0, bus.flags}, 32'b101);
        op1(OP_CLRC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("sr clrc flags", {29'd0, bus.flags}, 32'b001);
        op1(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b1);
        check("sr add+restore flags", {29'd0, bus.flags}, 32'b101);
        check("sr add+restore result", {16'd0, bus.result}, 32'h0003);
        check("sr add+restore out_valid", {31'd0, bus.out_valid}, 32'd1);
        op1(OP_CLRC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        op1(OP_ADD, 16'h8000, 16'h0000, 1'b1, 1'b1);
        check("sr both flags", {29'd0, bus.flags}, 32'b101);
        check("sr both result", {16'd0, bus.result}, 32'h8000);
        op1(OP_CLRC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("sr clrc2 flags", {29'd0, bus.flags}, 32'b001);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1);
        tick();
        check("sr shadow kept", {29'd0, bus.flags}, 32'b101);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        // backpressure: 4 back-to-back MOVs, out_ready low for 3 edges
        bus.out_ready = 1'b0;
        drive(1'b1, OP_MOV, 16'h1111, 16'h0000, 4'd0, 1'b0, 1'b0);
        #1;
        check("bp in_ready idle", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp r1", {16'd0, bus.result}, 32'h1111);
        check("bp v1", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b1, OP_MOV, 16'h2222, 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("bp stall in_ready %0d", k), {31'd0, bus.in_ready}, 32'd0);
            tick();
            check($sformatf("bp held result %0d", k), {16'd0, bus.result}, 32'h1111);
            check($sformatf("bp held valid %0d", k), {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp r2", {16'd0, bus.result}, 32'h2222);
        drive(1'b1, OP_MOV, 16'h3333, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check("bp r3", {16'd0, bus.result}, 32'h3333);
        drive(1'b1, OP_MOV, 16'h4444, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check("bp r4", {16'd0, bus.result}, 32'h4444);
        check("bp v4", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check("bp drained", {31'd0, bus.out_valid}, 32'd0);
        check("bp flags kept", {29'd0, bus.flags}, 32'b101);

`ifdef ALU_MUL_EN
        op1(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0);
        check("pre-mul flags", {29'd0, bus.flags}, 32'b000);
        mul_run(16'h0100, 16'h0100, 16'h0000, 3'b101);
        mul_run(16'h1234, 16'h0010, 16'h2340, 3'b100);
        mul_run(16'hFFFF, 16'hFFFF, 16'h0001, 3'b100);
        mul_run(16'h0003, 16'h0005, 16'h000F, 3'b000);

        // reset in the middle of a multiply
        op1(OP_SETC, 16'h0000, 16'h0000, 1'b1, 1'b0);
        drive(1'b1, OP_MUL, 16'h0100, 16'h0100, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("mulrst result", {16'd0, bus.result}, 32'd0);
        check("mulrst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mulrst flags", {29'd0, bus.flags}, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            check($sformatf("mulrst no valid c%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end
        check("mulrst in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1);
        tick();
        check("mulrst shadow cleared", {29'd0, bus.flags}, 32'd0);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
`else
        // opcode 13 without the multiplier behaves as NOP
        op1(4'd13, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        check("op13 result", {16'd0, bus.result}, 32'd0);
        check("op13 out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("op13 flags", {29'd0, bus.flags}, 32'b101);
        check("op13 in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor ALU for the execute stage. Accepts one encoded operation per cycle over a valid/ready handshake, registers the result, and maintains a Z/N/C flag register with a one-deep shadow copy for interrupt save/restore. Sits between the decode/ID-EX register and the EX-MEM register; backpressure from downstream stalls issue.

## Interface
- `WIDTH`, 16: operand/result width (≥4).
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: operation accepted this edge when `in_valid && in_ready`.
- `op` in 4: opcode (see Operation).
- `op_a` in WIDTH: first operand (source).
- `op_b` in WIDTH: second operand (destination value).
- `shamt` in SHW: shift amount.
- `flag_save` in 1: copy flags to shadow.
- `flag_restore` in 1: copy shadow to flags.
- `out_valid` out 1: `result` holds an unconsumed result.
- `out_ready` in 1: downstream consumes when `out_valid && out_ready`.
- `result` out WIDTH: registered result.
- `flags` out 3: [0]=Z, [1]=N, [2]=C.

## Operation
- Opcodes: 0 NOP, 1 NOT (~b), 2 INC (b+1), 3 DEC (b-1), 4 MOV (a), 5 ADD (a+b), 6 SUB (b-a), 7 AND, 8 OR, 9 SHL (b<<shamt), 10 SHR (b>>shamt, logical), 11 SETC, 12 CLRC, 13 MUL (macro only). 14, 15 and 13 without the macro execute as NOP.
- NOP/SETC/CLRC produce `result` = 0 and still assert `out_valid`, so slot accounting is preserved.
- Arithmetic is computed at WIDTH+1 bits. C = carry-out for INC/ADD, borrow (b<a unsigned, or b==0 for DEC) for SUB/DEC.
- SHL: C = b[WIDTH-shamt]. SHR: C = b[shamt-1]. shamt=0 gives result=b and leaves C unchanged.
- Z = (result==0). N = result[WIDTH-1], i.e. a signed sign bit, not an unsigned compare.
- Flag writes per op:
  - NOT/AND/OR: Z,N.
  - INC/DEC/ADD/SUB/SHL/SHR/MUL: Z,N,C.
  - SETC/CLRC: C only.
  - NOP/MOV: none.
- Save/restore:
  - `flag_save`: shadow <= flags as updated by any op accepted that same edge.
  - `flag_restore`: flags <= shadow, overriding any op flag write that edge.
  - Save and restore in the same cycle: restore wins, shadow unchanged.

## Timing
- Latency is 1 cycle: an op accepted at edge N has `result`/`out_valid` valid after edge N, and flags update at edge N.
- `in_ready` = !busy && (!out_valid || out_ready), giving full throughput of 1 op/cycle under continuous `out_ready`.
- `out_valid` clears on consume unless a new op is accepted the same edge. `result` holds stable while `out_valid && !out_ready`.
- Reset values: `result`=0, `out_valid`=0, `flags`=0, shadow=0, FSM IDLE, `in_ready`=1 after reset deasserts.
- Reset mid-multiply aborts the multiply. No result is produced.

## Configuration
- `ALU_MUL_EN` defined:
  - Opcode 13 runs an unsigned shift-add multiply.
  - FSM: IDLE -> MUL on accept; WIDTH iterations (one per cycle); MUL -> IDLE when the count reaches WIDTH-1, which registers the result.
  - busy=1 in MUL, so `in_ready`=0.
  - `result` = low WIDTH bits of the product; C = |high WIDTH bits.
  - Total latency is WIDTH cycles from accept to `out_valid`. Flags update on that same edge.
- `ALU_MUL_EN` undefined: opcode 13 is a NOP, there is no FSM, and busy is tied to 0.

## Structure
- Package `alu_pkg` holds:
  - the opcode enum `alu_op_e`;
  - flag indices `FLG_Z=0`, `FLG_N=1`, `FLG_C=2`;
  - a per-opcode flag-write mask function.
- Sub-module `alu_mul_seq`: the iterative multiplier with its own FSM, present only under `ALU_MUL_EN`, with `start`/`done` ports.

## Test plan
- WIDTH=16; ADD a=0x0001 b=0xFFFF -> result 0x0000, flags Z=1 N=0 C=1, `out_valid` one cycle after accept.
- SUB a=5 b=3 -> result 0xFFFE, N=1 C=1 Z=0; then MOV a=0 -> result 0, flags unchanged.
- SHL b=0x8001 shamt=1 -> 0x0002, C=1; SHR b=0x0001 shamt=0 -> 0x0001, C unchanged.
- Back-to-back 4 ops with `out_ready`=0 for 3 cycles -> first result held, `in_ready`=0 during the stall, no loss, in-order outputs.
- SETC, `flag_save`, CLRC, `flag_restore` in the same cycle as an ADD producing C=0 -> flags restored (C=1), ADD result still delivered.
- With `ALU_MUL_EN`: MUL a=0x0100 b=0x0100 -> result 0x0000, C=1, Z=1 after 16 cycles, `in_ready`=0 throughout; assert `rst` at cycle 8 -> no `out_valid`, all outputs 0.
